lifo_stack_param: RTL and testbench

Parametrised synchronous LIFO stack, the next generation of the team's fixed 8x8 stack. It adds:
- configurable data width and depth;
- an explicit element count and programmable almost-full/almost-empty flags;
- a combinational top-of-stack peek;
- a defined simultaneous push+pop (replace/bypass) behaviour;
- overflow and underflow error pulses.

It sits between a producer issuing push requests and a consumer issuing pop requests, as a local scratch stack in datapath blocks.

---
 rtl/lifo_pkg.sv | 20 ++
 rtl/lifo_stack_param_mem.sv | 28 ++
 rtl/lifo_stack_param.sv | 137 +++++++++++++
 tb/tb_lifo_stack_param.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/lifo_pkg.sv
// Shared types and helpers for the parametrised LIFO stack.
package lifo_pkg;

  // One operation is selected per cycle from push, pop, empty and full.
  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE,
    OP_BYPASS,
    OP_OVF,
    OP_UNF
  } op_t;

  // Width needed to hold every count value from 0 up to and including depth.
  function automatic int calc_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lifo_stack_param_mem.sv
// Storage array for the LIFO: one synchronous write port, one combinational read port.
module lifo_stack_param_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // Contents are deliberately not reset; only written entries are ever exposed.
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Single write port, addressed by the top-level op decoder.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Combinational read of the current top entry.
  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/lifo_stack_param.sv
// Parametrised synchronous LIFO stack with count, programmable almost flags,
// combinational top peek, push+pop replace/bypass and overflow/underflow pulses.
module lifo_stack_param
  import lifo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  parameter int CNT_W    = calc_cnt_w(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [DATA_W-1:0] top,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  op_t               op;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [AW-1:0]     top_addr;
  logic [DATA_W-1:0] mem_rdata;

  // count doubles as the stack pointer: next free slot is count, top is count-1.
  assign top_addr = AW'(count_q - ONE_C);

  lifo_stack_param_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clock   (clock),
    .wr_en   (mem_we),
    .wr_addr (mem_waddr),
    .wr_data (din),
    .rd_addr (top_addr),
    .rd_data (mem_rdata)
  );

  // Decode the cycle's operation from the requests and the current fill state.
  always_comb begin
    op = OP_IDLE;
    if (push && pop) begin
      op = empty ? OP_BYPASS : OP_REPLACE;
    end else if (push) begin
      op = full ? OP_OVF : OP_PUSH;
    end else if (pop) begin
      op = empty ? OP_UNF : OP_POP;
    end
  end

  // Next-state and memory write control for each operation.
  always_comb begin
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    overflow_d   = 1'b0;
    underflow_d  = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = AW'(count_q);
    case (op)
      OP_PUSH: begin
        mem_we  = 1'b1;
        count_d = count_q + ONE_C;
      end
      OP_POP: begin
        dout_d       = mem_rdata;
        dout_valid_d = 1'b1;
        count_d      = count_q - ONE_C;
      end
      OP_REPLACE: begin
        // Old top leaves through dout while din overwrites it in place.
        dout_d       = mem_rdata;
        dout_valid_d = 1'b1;
        mem_we       = 1'b1;
        mem_waddr    = top_addr;
      end
      OP_BYPASS: begin
        dout_d       = din;
        dout_valid_d = 1'b1;
      end
      OP_OVF:  overflow_d  = 1'b1;
      OP_UNF:  underflow_d = 1'b1;
      default: ;
    endcase
  end

  // State and output registers; reset wins over any request in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  assign count        = count_q;
  assign dout         = dout_q;
  assign dout_valid   = dout_valid_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (int'(count_q) >= AF_LEVEL);
  assign almost_empty = (int'(count_q) <= AE_LEVEL);
  assign top          = empty ? '0 : mem_rdata;

endmodule

// File: tb/tb_lifo_stack_param.sv
// Self-checking bench: two stack instances (8 deep default flags, 16 deep with
// AF=12/AE=2) against a queue-based stack model, directed cases then random traffic.
module tb_lifo_stack_param;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // Instance A: DEPTH=8 defaults.
  logic       push_a, pop_a;
  logic [7:0] din_a, dout_a, top_a;
  logic       dout_valid_a, full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
  logic [3:0] count_a;

  // Instance B: DEPTH=16, AF_LEVEL=12, AE_LEVEL=2.
  logic       push_b, pop_b;
  logic [7:0] din_b, dout_b, top_b;
  logic       dout_valid_b, full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
  logic [4:0] count_b;

  lifo_stack_param #(.DATA_W(8), .DEPTH(8)) u_dut_a (
    .clock(clock), .reset(reset), .push(push_a), .pop(pop_a), .din(din_a),
    .dout(dout_a), .dout_valid(dout_valid_a), .top(top_a), .count(count_a),
    .full(full_a), .empty(empty_a), .almost_full(af_a), .almost_empty(ae_a),
    .overflow(ovf_a), .underflow(unf_a)
  );

  lifo_stack_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(2)) u_dut_b (
    .clock(clock), .reset(reset), .push(push_b), .pop(pop_b), .din(din_b),
    .dout(dout_b), .dout_valid(dout_valid_b), .top(top_b), .count(count_b),
    .full(full_b), .empty(empty_b), .almost_full(af_b), .almost_empty(ae_b),
    .overflow(ovf_b), .underflow(unf_b)
  );

  int total  = 0;
  int passed = 0;

  // Behavioural model: a plain queue per instance, back = top of stack.
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  logic [7:0] m_dout  [2];
  logic       m_valid [2];
  logic       m_ovf   [2];
  logic       m_unf   [2];

  task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    for (int i = 0; i < 2; i++) begin
      m_dout[i] = 8'h00; m_valid[i] = 1'b0; m_ovf[i] = 1'b0; m_unf[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input logic p, input logic o, input logic [7:0] d);
    logic [7:0] q[$];
    int n;
    int dep;
    if (i == 0) begin q = mq0; dep = 8; end
    else        begin q = mq1; dep = 16; end
    n = q.size();
    m_valid[i] = 1'b0; m_ovf[i] = 1'b0; m_unf[i] = 1'b0;
    if (p && o) begin
      m_valid[i] = 1'b1;
      if (n == 0) m_dout[i] = d;
      else begin m_dout[i] = q[n-1]; q[n-1] = d; end
    end else if (p) begin
      if (n == dep) m_ovf[i] = 1'b1;
      else q.push_back(d);
    end else if (o) begin
      if (n == 0) m_unf[i] = 1'b1;
      else begin m_dout[i] = q.pop_back(); m_valid[i] = 1'b1; end
    end
    if (i == 0) mq0 = q; else mq1 = q;
  endtask

  // Full comparison of both instances against the model.
  task automatic compare_all();
    int n;
    n = mq0.size();
    chkv("a.count", 32'(count_a), n);
    chkv("a.dout", 32'(dout_a), 32'(m_dout[0]));
    chkb("a.dout_valid", dout_valid_a, m_valid[0]);
    chkb("a.overflow", ovf_a, m_ovf[0]);
    chkb("a.underflow", unf_a, m_unf[0]);
    chkv("a.top", 32'(top_a), (n > 0) ? 32'(mq0[n-1]) : 32'd0);
    chkb("a.full", full_a, n == 8);
    chkb("a.empty", empty_a, n == 0);
    chkb("a.almost_full", af_a, n >= 7);
    chkb("a.almost_empty", ae_a, n <= 1);
    n = mq1.size();
    chkv("b.count", 32'(count_b), n);
    chkv("b.dout", 32'(dout_b), 32'(m_dout[1]));
    chkb("b.dout_valid", dout_valid_b, m_valid[1]);
    chkb("b.overflow", ovf_b, m_ovf[1]);
    chkb("b.underflow", unf_b, m_unf[1]);
    chkv("b.top", 32'(top_b), (n > 0) ? 32'(mq1[n-1]) : 32'd0);
    chkb("b.full", full_b, n == 16);
    chkb("b.empty", empty_b, n == 0);
    chkb("b.almost_full", af_b, n >= 12);
    chkb("b.almost_empty", ae_b, n <= 2);
  endtask

  // One clock of traffic on instance i; inputs change on the falling edge.
  task automatic step(input int i, input logic p, input logic o, input logic [7:0] d);
    push_a = (i == 0) && p; pop_a = (i == 0) && o; din_a = d;
    push_b = (i == 1) && p; pop_b = (i == 1) && o; din_b = d;
    @(posedge clock);
    model_step(0, (i == 0) && p, (i == 0) && o, d);
    model_step(1, (i == 1) && p, (i == 1) && o, d);
    @(negedge clock);
    push_a = 1'b0; pop_a = 1'b0; push_b = 1'b0; pop_b = 1'b0;
    compare_all();
  endtask

  // Reset for one edge; whatever requests are currently driven stay driven.
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    push_a = 1'b0; pop_a = 1'b0; push_b = 1'b0; pop_b = 1'b0;
    compare_all();
  endtask

  initial begin
    int bias;
    reset = 1'b1;
    push_a = 1'b0; pop_a = 1'b0; din_a = 8'h00;
    push_b = 1'b0; pop_b = 1'b0; din_b = 8'h00;
    @(negedge clock);
    do_reset();
    chkb("rst.empty", empty_a, 1'b1);
    chkv("rst.top", 32'(top_a), 32'h0);

    // Push three, pop three.
    step(0, 1, 0, 8'h11); chkv("t1.count1", 32'(count_a), 1);
    step(0, 1, 0, 8'h22); chkv("t1.count2", 32'(count_a), 2);
    step(0, 1, 0, 8'h33); chkv("t1.count3", 32'(count_a), 3);
    chkv("t1.top", 32'(top_a), 32'h33);
    step(0, 0, 1, 8'h00); chkv("t1.pop1", 32'(dout_a), 32'h33); chkb("t1.v1", dout_valid_a, 1'b1);
    step(0, 0, 1, 8'h00); chkv("t1.pop2", 32'(dout_a), 32'h22); chkv("t1.cnt_p2", 32'(count_a), 1);
    step(0, 0, 1, 8'h00); chkv("t1.pop3", 32'(dout_a), 32'h11); chkb("t1.empty", empty_a, 1'b1);

    // Fill, overflow, pop.
    for (int k = 0; k < 8; k++) step(0, 1, 0, 8'(k));
    step(0, 1, 0, 8'hAA);
    chkb("t2.ovf", ovf_a, 1'b1); chkv("t2.count", 32'(count_a), 8);
    chkv("t2.top", 32'(top_a), 32'h07); chkb("t2.full", full_a, 1'b1);
    step(0, 0, 1, 8'h00); chkv("t2.pop", 32'(dout_a), 32'h07);

    // Replace with 3 entries, then replace while full.
    do_reset();
    step(0, 1, 0, 8'h11); step(0, 1, 0, 8'h22); step(0, 1, 0, 8'h33);
    step(0, 1, 1, 8'h44);
    chkv("t3.dout", 32'(dout_a), 32'h33); chkv("t3.top", 32'(top_a), 32'h44);
    chkv("t3.count", 32'(count_a), 3);
    for (int k = 0; k < 5; k++) step(0, 1, 0, 8'(8'h55 + 8'(k * 17)));
    step(0, 1, 1, 8'hBB);
    chkb("t3.no_ovf", ovf_a, 1'b0); chkv("t3.count_full", 32'(count_a), 8);
    chkv("t3.dout_full", 32'(dout_a), 32'h99); chkv("t3.top_full", 32'(top_a), 32'hBB);

    // Bypass on empty, then underflow.
    do_reset();
    step(0, 1, 1, 8'h5A);
    chkv("t4.dout", 32'(dout_a), 32'h5A); chkb("t4.valid", dout_valid_a, 1'b1);
    chkv("t4.count", 32'(count_a), 0); chkb("t4.no_unf", unf_a, 1'b0);
    step(0, 0, 1, 8'h00);
    chkb("t4.unf", unf_a, 1'b1); chkv("t4.hold", 32'(dout_a), 32'h5A);
    chkb("t4.novalid", dout_valid_a, 1'b0);

    // Almost flags on the 16-deep instance.
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      step(1, 1, 0, 8'(k));
      if (k == 2)  chkb("t5.ae_up2", ae_b, 1'b1);
      if (k == 3)  chkb("t5.ae_up3", ae_b, 1'b0);
      if (k == 11) chkb("t5.af_up11", af_b, 1'b0);
      if (k == 12) chkb("t5.af_up12", af_b, 1'b1);
    end
    chkb("t5.full", full_b, 1'b1);
    for (int k = 15; k >= 0; k--) begin
      step(1, 0, 1, 8'h00);
      if (k == 12) chkb("t5.af_dn12", af_b, 1'b1);
      if (k == 11) chkb("t5.af_dn11", af_b, 1'b0);
      if (k == 3)  chkb("t5.ae_dn3", ae_b, 1'b0);
      if (k == 2)  chkb("t5.ae_dn2", ae_b, 1'b1);
    end
    chkv("t5.last", 32'(dout_b), 32'h01);

    // Reset with 5 entries and a push held.
    for (int k = 1; k <= 5; k++) step(0, 1, 0, 8'(k));
    step(0, 0, 1, 8'h00);
    step(0, 1, 0, 8'h66);
    chkv("t6.pre", 32'(count_a), 5);
    push_a = 1'b1; din_a = 8'hEE;
    do_reset();
    chkv("t6.count", 32'(count_a), 0); chkv("t6.dout", 32'(dout_a), 32'h0);
    chkb("t6.empty", empty_a, 1'b1); chkv("t6.top", 32'(top_a), 32'h0);

    // Random traffic, alternating fill/drain bias, occasional reset.
    for (int c = 0; c < 3000; c++) begin
      bias = ((c / 64) % 2 == 0) ? 70 : 30;
      if ($urandom_range(0, 299) == 0) do_reset();
      else step(int'($urandom_range(0, 1)),
                $urandom_range(0, 99) < bias,
                $urandom_range(0, 99) < (100 - bias),
                8'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
